// File: rtl/satd_pkg.sv
// Shared constants, row types and clip helpers for the SATD/reconstruction path.
package satd_pkg;

    localparam int unsigned N    = 8;
    localparam int unsigned PW   = 8;
    localparam int unsigned RW   = 9;
    localparam int unsigned SUMW = 10;
    // Clip counter is wide enough for all 64 samples of a block to clip.
    localparam int unsigned CCW  = 7;

    typedef logic [N-1:0][PW-1:0] pix_row_t;
    typedef logic signed [N-1:0][RW-1:0] res_row_t;

    // Saturate a signed pred+res sum to an unsigned pixel.
    function automatic logic [PW-1:0] clip_pix(input logic signed [SUMW-1:0] sum);
        logic [PW-1:0] r;
        if (sum[SUMW-1]) begin
            r = '0;
        end else if (sum[SUMW-2] != 1'b0) begin
            r = '1;
        end else begin
            r = sum[PW-1:0];
        end
        return r;
    endfunction

    // True when clip_pix would change the sum (below 0 or above 255).
    function automatic logic clip_flag(input logic signed [SUMW-1:0] sum);
        return sum[SUMW-1] | sum[SUMW-2];
    endfunction

endpackage

// File: rtl/recon_lane.sv
// One sample lane: stage 1 adds pred and residual, stage 2 clips to a pixel.
// With RECONSTRUCTION_CLIP_COUNT_EN defined the lane also reports whether the
// sample waiting in stage 1 will clip.
module recon_lane
    import satd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en1,
    input  logic          en2,
    input  logic [PW-1:0] pred,
    input  logic [RW-1:0] res,
    output logic [PW-1:0] rec
`ifdef RECONSTRUCTION_CLIP_COUNT_EN
    ,
    output logic          clip_c
`endif
);

    logic signed [SUMW-1:0] sum_c;
    logic signed [SUMW-1:0] s1_sum;

    assign sum_c = $signed({2'b00, pred}) + $signed({res[RW-1], res});

    // Stage 1 register: holds the unclipped sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sum <= '0;
        end else if (en1) begin
            s1_sum <= sum_c;
        end
    end

    // Stage 2 register: holds the clipped pixel presented downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec <= '0;
        end else if (en2) begin
            rec <= clip_pix(s1_sum);
        end
    end

`ifdef RECONSTRUCTION_CLIP_COUNT_EN
    assign clip_c = clip_flag(s1_sum);
`endif

endmodule

// File: rtl/reconstruction.sv
// Row reconstruction: rec = clip(pred + res) over 8 lanes through a 2-stage
// valid/ready pipeline, with positional 8-row block framing.
// Optional feature macro: RECONSTRUCTION_CLIP_COUNT_EN adds clip_cnt, the
// number of clipped samples so far in the current block.
module reconstruction
    import satd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*PW-1:0]     pred,
    input  logic [N*RW-1:0]     res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*PW-1:0]     rec,
    output logic [2:0]          out_row,
    output logic                out_last
`ifdef RECONSTRUCTION_CLIP_COUNT_EN
    ,
    output logic [CCW-1:0]      clip_cnt
`endif
);

    logic       s1_valid;
    logic       s2_valid;
    logic       adv1;
    logic       adv2;
    logic       en1;
    logic       en2;
    logic [2:0] row_cnt;

    pix_row_t   pred_row;
    res_row_t   res_row;
    pix_row_t   rec_row;

    assign pred_row = pred;
    assign res_row  = res;
    assign rec      = rec_row;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign en1      = adv1 && in_valid;
    assign en2      = adv2 && s1_valid;

    assign in_ready  = adv1;
    assign out_valid = s2_valid;
    assign out_row   = row_cnt;
    assign out_last  = s2_valid && (row_cnt == 3'd7);

`ifdef RECONSTRUCTION_CLIP_COUNT_EN
    logic [N-1:0] clip_c;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        recon_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .en1    (en1),
            .en2    (en2),
            .pred   (pred_row[i]),
            .res    (res_row[i]),
            .rec    (rec_row[i])
`ifdef RECONSTRUCTION_CLIP_COUNT_EN
            ,
            .clip_c (clip_c[i])
`endif
        );
    end

    // Stage valid flags advance whenever the stage ahead can take a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Row index of the row on rec; steps on each output handshake, wraps 7->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            row_cnt <= row_cnt + 3'd1;
        end
    end

`ifdef RECONSTRUCTION_CLIP_COUNT_EN
    logic [CCW-1:0] pop_c;
    logic [2:0]     load_row_c;

    // Clipped-lane count of the row entering stage 2 and that row's index.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N; i++) begin
            pop_c = pop_c + CCW'(clip_c[i]);
        end
        load_row_c = s2_valid ? (row_cnt + 3'd1) : row_cnt;
    end

    // Running block total, registered alongside the row it includes.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt <= '0;
        end else if (en2) begin
            clip_cnt <= ((load_row_c == 3'd0) ? CCW'(0) : clip_cnt) + pop_c;
        end
    end
`endif

endmodule
